// File: rtl/cpu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | cpu_pkg : widths, access-size codes and memory-stage state encoding
// | Rev 1.0 : initial release
// +---------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int TAG_W  = 8;
   localparam int RIDX_W = 5;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // Width code 3 falls into the word case, so anything not byte/half is word.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (width == MEM_HALF)
         mis = addr_lo[0];
      else if (width != MEM_BYTE)
         mis = (addr_lo != 2'b00);
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_memory_align.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | cpu_memory_align : store lane/mask generation, load extraction, misalign
// | Rev 1.0 : initial release
// +---------------------------------------------------------------------------
module cpu_memory_align
   import cpu_pkg::*;
(
   input  logic [1:0]      i_st_addr_lo,
   input  logic [1:0]      i_st_width,
   input  logic [XLEN-1:0] i_st_data,
   output logic [XLEN-1:0] o_st_wdata,
   output logic [3:0]      o_st_wmask,
   output logic            o_misaligned,
   input  logic [1:0]      i_ld_addr_lo,
   input  logic [1:0]      i_ld_width,
   input  logic            i_ld_signed,
   input  logic [XLEN-1:0] i_ld_rdata,
   output logic [XLEN-1:0] o_ld_value
);

   logic [XLEN-1:0] w_lane;

   assign o_misaligned = is_misaligned(i_st_width, i_st_addr_lo);

   always_comb begin
      o_st_wdata = i_st_data;
      o_st_wmask = 4'b1111;
      case (i_st_width)
         MEM_BYTE: begin
            o_st_wdata = {4{i_st_data[7:0]}};
            o_st_wmask = 4'b0001 << i_st_addr_lo;
         end
         MEM_HALF: begin
            o_st_wdata = {2{i_st_data[15:0]}};
            o_st_wmask = 4'b0011 << i_st_addr_lo;
         end
         default: begin
            o_st_wdata = i_st_data;
            o_st_wmask = 4'b1111;
         end
      endcase
   end

   // Requested bytes are shifted down to bit 0 before extension.
   assign w_lane = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

   always_comb begin
      o_ld_value = w_lane;
      case (i_ld_width)
         MEM_BYTE: o_ld_value = {{24{i_ld_signed & w_lane[7]}}, w_lane[7:0]};
         MEM_HALF: o_ld_value = {{16{i_ld_signed & w_lane[15]}}, w_lane[15:0]};
         default:  o_ld_value = w_lane;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/cpu_memory.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | cpu_memory : memory pipeline stage, load/store over a request/ready bus
// | Rev 1.0 : initial release
// +---------------------------------------------------------------------------
module cpu_memory
   import cpu_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic [RIDX_W-1:0] i_inst_rd,
   input  logic [XLEN-1:0]   i_rd,
   input  logic              i_branch,
   input  logic [XLEN-1:0]   i_pc_next,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [XLEN-1:0]   i_mem_address,
   input  logic [1:0]        i_mem_width,
   input  logic              i_mem_signed,
   output logic              o_busy,
   output logic              o_bus_request,
   output logic              o_bus_rw,
   output logic [XLEN-1:0]   o_bus_address,
   output logic [XLEN-1:0]   o_bus_wdata,
   output logic [3:0]        o_bus_wmask,
   input  logic [XLEN-1:0]   i_bus_rdata,
   input  logic              i_bus_ready,
   output logic [TAG_W-1:0]  o_tag,
   output logic [RIDX_W-1:0] o_inst_rd,
   output logic [XLEN-1:0]   o_rd,
   output logic              o_branch,
   output logic [XLEN-1:0]   o_pc_next,
   output logic              o_fault
);

   state_t              r_state;
   logic [TAG_W-1:0]    r_tag;
   logic [RIDX_W-1:0]   r_inst_rd;
   logic                r_branch;
   logic [XLEN-1:0]     r_pc_next;
   logic [1:0]          r_addr_lo;
   logic [1:0]          r_width;
   logic                r_signed;

   logic                w_accept;
   logic                w_mem_op;
   logic                w_misaligned;
   logic [XLEN-1:0]     w_st_wdata;
   logic [3:0]          w_st_wmask;
   logic [XLEN-1:0]     w_ld_value;

   assign o_busy   = (r_state != ST_IDLE);
   assign w_accept = (r_state == ST_IDLE) && (i_tag != o_tag);
   assign w_mem_op = i_mem_read | i_mem_write;

   cpu_memory_align u_align (
      .i_st_addr_lo (i_mem_address[1:0]),
      .i_st_width   (i_mem_width),
      .i_st_data    (i_rd),
      .o_st_wdata   (w_st_wdata),
      .o_st_wmask   (w_st_wmask),
      .o_misaligned (w_misaligned),
      .i_ld_addr_lo (r_addr_lo),
      .i_ld_width   (r_width),
      .i_ld_signed  (r_signed),
      .i_ld_rdata   (i_bus_rdata),
      .o_ld_value   (w_ld_value)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_tag         <= '0;
         r_inst_rd     <= '0;
         r_branch      <= 1'b0;
         r_pc_next     <= '0;
         r_addr_lo     <= 2'b00;
         r_width       <= MEM_BYTE;
         r_signed      <= 1'b0;
         o_tag         <= '0;
         o_inst_rd     <= '0;
         o_rd          <= '0;
         o_branch      <= 1'b0;
         o_pc_next     <= '0;
         o_fault       <= 1'b0;
         o_bus_request <= 1'b0;
         o_bus_rw      <= 1'b0;
         o_bus_address <= '0;
         o_bus_wdata   <= '0;
         o_bus_wmask   <= 4'b0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_tag     <= i_tag;
                  r_inst_rd <= i_inst_rd;
                  r_branch  <= i_branch;
                  r_pc_next <= i_pc_next;
                  r_addr_lo <= i_mem_address[1:0];
                  r_width   <= i_mem_width;
                  r_signed  <= i_mem_signed;
                  if (!w_mem_op) begin
                     o_tag     <= i_tag;
                     o_inst_rd <= i_inst_rd;
                     o_rd      <= i_rd;
                     o_branch  <= i_branch;
                     o_pc_next <= i_pc_next;
                     o_fault   <= 1'b0;
                  end else if (w_misaligned) begin
                     // Faulting access retires at once without touching the bus.
                     o_tag     <= i_tag;
                     o_inst_rd <= '0;
                     o_branch  <= i_branch;
                     o_pc_next <= i_pc_next;
                     o_fault   <= 1'b1;
                     if (i_mem_read)
                        o_rd <= '0;
                  end else begin
                     o_inst_rd     <= '0;
                     o_bus_request <= 1'b1;
                     o_bus_address <= {i_mem_address[XLEN-1:2], 2'b00};
                     if (i_mem_read) begin
                        o_bus_rw    <= 1'b0;
                        o_bus_wdata <= '0;
                        o_bus_wmask <= 4'b0000;
                        r_state     <= ST_READ;
                     end else begin
                        o_bus_rw    <= 1'b1;
                        o_bus_wdata <= w_st_wdata;
                        o_bus_wmask <= w_st_wmask;
                        r_state     <= ST_WRITE;
                     end
                  end
               end
            end
            ST_READ, ST_WRITE: begin
               if (i_bus_ready) begin
                  o_bus_request <= 1'b0;
                  o_tag         <= r_tag;
                  o_branch      <= r_branch;
                  o_pc_next     <= r_pc_next;
                  o_fault       <= 1'b0;
                  r_state       <= ST_IDLE;
                  if (r_state == ST_READ) begin
                     o_rd      <= w_ld_value;
                     o_inst_rd <= r_inst_rd;
                  end else begin
                     o_inst_rd <= '0;
                  end
               end
            end
            default: begin
               o_bus_request <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | tb_cpu_memory : scoreboard bench for the memory stage with a directed bus model
// | Rev 1.0 : initial release
// +---------------------------------------------------------------------------
module tb_cpu_memory;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic [7:0]  i_tag = '0;
   logic [4:0]  i_inst_rd = '0;
   logic [31:0] i_rd = '0;
   logic        i_branch = 1'b0;
   logic [31:0] i_pc_next = '0;
   logic        i_mem_read = 1'b0;
   logic        i_mem_write = 1'b0;
   logic [31:0] i_mem_address = '0;
   logic [1:0]  i_mem_width = '0;
   logic        i_mem_signed = 1'b0;
   logic [31:0] i_bus_rdata = '0;
   logic        i_bus_ready = 1'b0;
   logic        o_busy, o_bus_request, o_bus_rw, o_branch, o_fault;
   logic [31:0] o_bus_address, o_bus_wdata, o_rd, o_pc_next;
   logic [3:0]  o_bus_wmask;
   logic [7:0]  o_tag;
   logic [4:0]  o_inst_rd;

   typedef struct {
      logic [7:0]  tag;
      logic [4:0]  inst_rd;
      logic [31:0] rd;
      logic        branch;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   exp_t        sb_q[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          busy_cnt = 0;
   logic [7:0]  prev_tag = '0;

   cpu_memory dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_tag(i_tag), .i_inst_rd(i_inst_rd),
      .i_rd(i_rd), .i_branch(i_branch), .i_pc_next(i_pc_next),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_mem_address(i_mem_address), .i_mem_width(i_mem_width),
      .i_mem_signed(i_mem_signed), .o_busy(o_busy), .o_bus_request(o_bus_request),
      .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
      .o_bus_wmask(o_bus_wmask), .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready),
      .o_tag(o_tag), .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_branch(o_branch),
      .o_pc_next(o_pc_next), .o_fault(o_fault)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   always @(negedge i_clock) busy_cnt += int'(o_busy);

   // Monitor: every change of o_tag outside reset is a result to score.
   always @(negedge i_clock) begin : mon
      exp_t e;
      if (i_reset) begin
         prev_tag = o_tag;
      end else if (o_tag !== prev_tag) begin
         prev_tag = o_tag;
         if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result: got tag 0x%02h expected none", o_tag);
         end else begin
            e = sb_q.pop_front();
            chk("res_tag", {24'd0, o_tag}, {24'd0, e.tag});
            chk("res_inst_rd", {27'd0, o_inst_rd}, {27'd0, e.inst_rd});
            chk("res_rd", o_rd, e.rd);
            chk("res_branch", {31'd0, o_branch}, {31'd0, e.branch});
            chk("res_pc_next", o_pc_next, e.pc);
            chk("res_fault", {31'd0, o_fault}, {31'd0, e.fault});
         end
      end
   end

   task automatic expect_res(input logic [7:0] tg, input logic [4:0] ri, input logic [31:0] rv,
                             input logic br, input logic [31:0] pc, input logic f);
      exp_t e;
      e.tag = tg; e.inst_rd = ri; e.rd = rv; e.branch = br; e.pc = pc; e.fault = f;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] tg, input logic [4:0] ri, input logic [31:0] rv,
                        input logic br, input logic [31:0] pc, input logic rd_en,
                        input logic wr_en, input logic [31:0] addr, input logic [1:0] w,
                        input logic sg);
      @(posedge i_clock); #1;
      i_tag = tg; i_inst_rd = ri; i_rd = rv; i_branch = br; i_pc_next = pc;
      i_mem_read = rd_en; i_mem_write = wr_en; i_mem_address = addr;
      i_mem_width = w; i_mem_signed = sg;
      busy_cnt = 0;
   endtask

   task automatic no_bus_retire(input string name);
      @(posedge i_clock);
      @(negedge i_clock); #1;
      chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({name, "_no_request"}, {31'd0, o_bus_request}, 32'd0);
   endtask

   task automatic bus_txn(input int wait_c, input logic [31:0] rdata, input logic exp_rw,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wmask);
      @(posedge i_clock);
      @(negedge i_clock); #1;
      chk("bus_request", {31'd0, o_bus_request}, 32'd1);
      chk("bus_rw", {31'd0, o_bus_rw}, {31'd0, exp_rw});
      chk("bus_address", o_bus_address, exp_addr);
      chk("bus_wmask", {28'd0, o_bus_wmask}, {28'd0, exp_wmask});
      if (exp_rw) chk("bus_wdata", o_bus_wdata, exp_wdata);
      chk("busy_inst_rd", {27'd0, o_inst_rd}, 32'd0);
      repeat (wait_c - 1) @(posedge i_clock);
      #1;
      chk("bus_request_held", {31'd0, o_bus_request}, 32'd1);
      i_bus_ready = 1'b1; i_bus_rdata = rdata;
      @(posedge i_clock); #1;
      i_bus_ready = 1'b0; i_bus_rdata = '0;
      @(negedge i_clock); #1;
      chk("busy_cycles", busy_cnt, wait_c);
      chk("request_dropped", {31'd0, o_bus_request}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      @(negedge i_clock); #1;
      chk("rst_tag", {24'd0, o_tag}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_request", {31'd0, o_bus_request}, 32'd0);
      chk("rst_rd", o_rd, 32'd0);
      chk("rst_wmask", {28'd0, o_bus_wmask}, 32'd0);
      chk("rst_fault", {31'd0, o_fault}, 32'd0);
      @(posedge i_clock); #1;
      i_reset = 1'b0;

      // ALU pass-through
      expect_res(8'd1, 5'd3, 32'h11, 1'b0, 32'h4, 1'b0);
      drive(8'd1, 5'd3, 32'h11, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
      no_bus_retire("pass1");
      expect_res(8'd2, 5'd5, 32'h1234, 1'b1, 32'h40, 1'b0);
      drive(8'd2, 5'd5, 32'h1234, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
      no_bus_retire("pass2");

      // Signed byte load, top lane, 3-cycle bus wait
      expect_res(8'd3, 5'd7, 32'hFFFF_FF80, 1'b0, 32'h44, 1'b0);
      drive(8'd3, 5'd7, 32'h0, 1'b0, 32'h44, 1'b1, 1'b0, 32'h103, 2'd0, 1'b1);
      bus_txn(3, 32'h80FF_FF00, 1'b0, 32'h100, 32'h0, 4'b0000);

      // Half store to upper half: o_rd keeps the previous load value
      expect_res(8'd4, 5'd0, 32'hFFFF_FF80, 1'b1, 32'h48, 1'b0);
      drive(8'd4, 5'd9, 32'hABCD_1234, 1'b1, 32'h48, 1'b0, 1'b1, 32'h202, 2'd1, 1'b0);
      bus_txn(1, 32'h0, 1'b1, 32'h200, 32'h1234_1234, 4'b1100);

      // Misaligned word load, then a pass-through clears the fault
      expect_res(8'd5, 5'd0, 32'h0, 1'b0, 32'h4C, 1'b1);
      drive(8'd5, 5'd6, 32'h999, 1'b0, 32'h4C, 1'b1, 1'b0, 32'h301, 2'd2, 1'b0);
      no_bus_retire("mis_load");
      expect_res(8'd6, 5'd2, 32'h55, 1'b0, 32'h50, 1'b0);
      drive(8'd6, 5'd2, 32'h55, 1'b0, 32'h50, 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
      no_bus_retire("pass3");

      // Misaligned half store: o_rd untouched
      expect_res(8'd7, 5'd0, 32'h55, 1'b0, 32'h54, 1'b1);
      drive(8'd7, 5'd4, 32'hCAFE, 1'b0, 32'h54, 1'b0, 1'b1, 32'h201, 2'd1, 1'b0);
      no_bus_retire("mis_store");

      // Byte store to lane 3
      expect_res(8'd8, 5'd0, 32'h55, 1'b0, 32'h58, 1'b0);
      drive(8'd8, 5'd3, 32'h1234_56A5, 1'b0, 32'h58, 1'b0, 1'b1, 32'h203, 2'd0, 1'b0);
      bus_txn(2, 32'h0, 1'b1, 32'h200, 32'hA5A5_A5A5, 4'b1000);

      // Width code 3 with read and write both high: word load wins
      expect_res(8'd9, 5'd10, 32'hDEAD_BEEF, 1'b0, 32'h5C, 1'b0);
      drive(8'd9, 5'd10, 32'h0, 1'b0, 32'h5C, 1'b1, 1'b1, 32'h400, 2'd3, 1'b1);
      bus_txn(1, 32'hDEAD_BEEF, 1'b0, 32'h400, 32'h0, 4'b0000);

      // Unsigned byte load to x0: value written, index stays 0
      expect_res(8'd10, 5'd0, 32'h81, 1'b0, 32'h60, 1'b0);
      drive(8'd10, 5'd0, 32'h0, 1'b0, 32'h60, 1'b1, 1'b0, 32'h101, 2'd0, 1'b0);
      bus_txn(2, 32'h0000_8100, 1'b0, 32'h100, 32'h0, 4'b0000);

      // Reset while READ is outstanding; a late ready must be ignored
      drive(8'd11, 5'd8, 32'h0, 1'b0, 32'h64, 1'b1, 1'b0, 32'h500, 2'd2, 1'b0);
      @(posedge i_clock);
      @(negedge i_clock); #1;
      chk("pre_rst_request", {31'd0, o_bus_request}, 32'd1);
      i_reset = 1'b1;
      #1;
      chk("mid_rst_request", {31'd0, o_bus_request}, 32'd0);
      chk("mid_rst_tag", {24'd0, o_tag}, 32'd0);
      chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      @(posedge i_clock); #1;
      i_tag = 8'd0; i_mem_read = 1'b0;
      @(negedge i_clock);
      @(posedge i_clock); #1;
      i_reset = 1'b0;
      i_bus_ready = 1'b1; i_bus_rdata = 32'h1234_5678;
      @(posedge i_clock); #1;
      i_bus_ready = 1'b0; i_bus_rdata = '0;
      @(negedge i_clock); #1;
      chk("late_ready_tag", {24'd0, o_tag}, 32'd0);
      chk("late_ready_rd", o_rd, 32'd0);
      chk("late_ready_busy", {31'd0, o_busy}, 32'd0);
      chk("late_ready_request", {31'd0, o_bus_request}, 32'd0);

      // Tag wrap 0xFF -> 0x00 with an unsigned half load from the upper half
      expect_res(8'hFF, 5'd1, 32'h77, 1'b0, 32'h64, 1'b0);
      drive(8'hFF, 5'd1, 32'h77, 1'b0, 32'h64, 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
      no_bus_retire("pass_ff");
      expect_res(8'h00, 5'd12, 32'h0000_8001, 1'b0, 32'h68, 1'b0);
      drive(8'h00, 5'd12, 32'h0, 1'b0, 32'h68, 1'b1, 1'b0, 32'h002, 2'd1, 1'b0);
      bus_txn(1, 32'h8001_0000, 1'b0, 32'h000, 32'h0, 4'b0000);

      repeat (3) @(posedge i_clock);
      @(negedge i_clock); #1;
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_memory.md
Name: cpu_memory

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes execute's tagged result bundle: tag, rd index/value, branch/pc_next, mem read/write request, address.
- Performs load/store over a simple request/ready data bus, with byte/half/word alignment and sign extension.
- Hands a tagged result to writeback, and stalls execute while a bus transaction is outstanding.

Parameters:
- None. Widths are fixed: XLEN 32, tag 8, register index 5.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_tag  in  8  execute output tag; a value differing from o_tag marks new work.
- i_inst_rd  in  5  destination register index (0 = no write).
- i_rd  in  32  ALU result, or store data when i_mem_write.
- i_branch  in  1  branch-taken flag, passed through.
- i_pc_next  in  32  next PC, passed through.
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_mem_address  in  32  byte address.
- i_mem_width  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- i_mem_signed  in  1  sign-extend loads when 1.
- o_busy  out  1  stall to execute (its i_stall).
- o_bus_request  out  1  bus request, held until ready.
- o_bus_rw  out  1  1 = write.
- o_bus_address  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_bus_wdata  out  32  lane-shifted store data.
- o_bus_wmask  out  4  byte enables.
- i_bus_rdata  in  32  read data, valid with i_bus_ready.
- i_bus_ready  in  1  one-cycle completion strobe.
- o_tag  out  8  output tag to writeback.
- o_inst_rd  out  5  destination register index.
- o_rd  out  32  result value.
- o_branch  out  1  branch flag.
- o_pc_next  out  32  next PC.
- o_fault  out  1  misaligned access flag for the current o_tag.

Behaviour:
- Reset (async, i_reset high):
  - State goes to IDLE.
  - Outputs cleared: o_tag=0, o_inst_rd=0, o_rd=0, o_branch=0, o_pc_next=0, o_fault=0, o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0, o_bus_wmask=0.
  - Reset mid-transaction abandons it; no result is ever produced for that tag.
- o_busy = (state != IDLE), combinational from state.
- States: IDLE, READ, WRITE.
- IDLE:
  - Accept when i_tag != o_tag. All inputs are latched internally at acceptance.
  - No memory op: register pass-through of tag, rd index, rd, branch, pc_next; o_fault=0. Latency 1 cycle. Stay IDLE.
  - Misaligned op (half with addr[0]=1, or word with addr[1:0]!=0):
    - No bus cycle is issued.
    - Load: o_rd=0, o_inst_rd=0. Store: o_inst_rd=0.
    - o_fault=1; o_tag updated in the same cycle; stay IDLE.
  - Aligned load: drive bus with rw=0 and wmask=0; go to READ.
  - Aligned store:
    - Byte: wdata = {4{rd[7:0]}}, wmask = 1<<addr[1:0].
    - Half: wdata = {2{rd[15:0]}}, wmask = 4'b0011<<addr[1:0].
    - Word: wdata = rd, wmask = 4'b1111.
    - Go to WRITE.
  - i_mem_read and i_mem_write both high: read wins.
- READ/WRITE:
  - o_bus_request and all bus fields are held stable until i_bus_ready.
  - o_inst_rd is driven 0 while busy, so forwarding never picks up a stale value.
  - On the i_bus_ready cycle:
    - Drop the request; return to IDLE.
    - Write o_tag, o_branch, o_pc_next.
  - Load result: lane = rdata >> (8*addr[1:0]).
    - Byte: 8 bits, sign- or zero-extended per i_mem_signed.
    - Half: 16 bits, extended likewise. Word: as is.
    - o_inst_rd = latched rd index.
  - Store result: o_inst_rd=0, o_rd unchanged.
  - Minimum load/store latency is 2 cycles (accept, then ready with zero bus wait).
- i_bus_ready while IDLE is ignored.
- A new tag arriving while busy is not sampled until IDLE.
- The tag compare is pure inequality, so tag wrap 0xFF→0x00 is handled.
- o_fault is cleared by the next accepted tag.
- Loads to rd index 0 write o_rd but keep o_inst_rd=0.

Decomposition:
- Shared package cpu_pkg:
  - Width constants MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2.
  - State encoding.
  - XLEN=32, TAG_W=8.
- One sub-module, cpu_memory_align (combinational):
  - Store lane/mask generation.
  - Load extraction and extension.
  - Misalignment detect.

Test Plan:
- ALU pass-through: i_tag 1→2, rd_idx=5, rd=0x1234, no mem → next edge o_tag=2, o_inst_rd=5, o_rd=0x1234; o_busy never high.
- Signed byte load: addr=0x103, signed, bus ready 3 cycles later with rdata=0x80FFFF00 → o_busy high for 3 cycles, o_rd=0xFFFFFF80, o_inst_rd as given, o_bus_address=0x100.
- Half store: addr=0x202, rd=0xABCD1234 → wmask=4'b1100, wdata=0x12341234, o_inst_rd=0 after ready.
- Misaligned word load: addr=0x301 → no o_bus_request, o_fault=1, o_rd=0; next tag clears o_fault.
- Async reset asserted during READ → request drops immediately, o_tag=0, state IDLE; a late i_bus_ready is ignored.
- Tag wrap 0xFF→0x00 with a zero-extended half load at addr=0x002, rdata=0x8001_0000 → o_rd=0x00008001, o_tag=0x00.
